lcd_char_buffer: RTL and testbench
==================================

Name: lcd_char_buffer

Overview:
- 2x16 ASCII screen buffer that sits directly upstream of the LCD nibble writer on the Spartan-3E board.
- Blackjack game logic writes characters at screen positions.
- Whenever the contents change, the buffer streams a full screen refresh to the writer as command/data bytes over a valid/ready handshake.
- The downstream writer owns all nibble splitting and LCD timing.

Parameters:
- BLANK, 8'h20, fill character used at reset and on clear.
- LINE1_CMD, 8'h80, Set-DDRAM-address command for line 1, position 0.
- LINE2_CMD, 8'hC0, Set-DDRAM-address command for line 2, position 0 (address h40).

Ports:
- clk  in  1  50 MHz board clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  write one character this cycle
- wr_addr  in  5  bit4 = line (0 top, 1 bottom); [3:0] = column
- wr_data  in  8  ASCII code
- clr  in  1  set all 32 entries to BLANK this cycle
- out_valid  out  1  a byte is offered downstream
- out_ready  in  1  downstream accepts the offered byte
- out_rs  out  1  0 = command byte, 1 = character data
- out_byte  out  8  byte offered downstream
- frame_busy  out  1  a refresh frame is in progress
- dirty  out  1  contents changed since the last frame started

Behaviour:
- Storage: 32 x 8 register array, indexed by wr_addr.
- Reset (rst_n=0 at a clk edge):
  - all entries = BLANK.
  - out_valid=0, out_rs=0, out_byte=8'h00, frame_busy=0.
  - dirty=1, so a blank screen is pushed after reset.
  - Reset mid-frame aborts the frame immediately; no partial transfer survives.
- Write and clear:
  - clr alone blanks all entries.
  - clr and wr_en in the same cycle: blank everything, then apply the write (the written address holds wr_data).
  - Any wr_en or clr sets dirty at the next edge.
- Handshake:
  - A transfer completes on a cycle with out_valid & out_ready.
  - out_rs and out_byte are registered; they hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on reset.
  - The next byte is loaded on the same edge as the transfer, so throughput is 1 byte/cycle when out_ready stays high.
- FSM states: IDLE, CMD1, LINE1, CMD2, LINE2.
  - IDLE -> CMD1 when dirty=1:
    - load {rs=0, LINE1_CMD}, out_valid=1, frame_busy=1.
    - dirty clears on this edge, unless wr_en or clr is also asserted that cycle (set wins).
  - CMD1 -> LINE1 on transfer; column counter = 0; offer {1, mem[0]}.
  - LINE1: each transfer advances the column.
    - After column 15 transfers -> CMD2, offering {0, LINE2_CMD}.
  - CMD2 -> LINE2 on transfer; offer {1, mem[16]}.
  - LINE2: after column 15 (mem[31]) transfers:
    - go to IDLE; out_valid=0 and frame_busy=0 on that edge.
    - If dirty=1, the next frame starts on the following cycle.
- Frame length: exactly 34 transfers.
- Data sampling: each character is sampled from the array when it is loaded into the output register.
  - A write to a position already sent, or currently offered, does not change the current frame.
  - That write sets dirty, so it appears in the next frame.
- Column counter wraps 15 -> 0 only via a state change; there is no out-of-range address.

Optional Feature:
- Macro: LCD_CHAR_BUFFER_INIT_EN.
- Defined: the first frame after each reset is preceded by an INIT state that emits four rs=0 bytes, 8'h28, 8'h06, 8'h0C, 8'h01 (function set, entry mode, display on, clear), then proceeds to CMD1.
  - That first frame is 38 transfers; later frames are 34.
  - An init_done flag (cleared by reset) tracks this.
- Undefined: no INIT state; every frame is 34 transfers.

Test Plan:
- Release rst_n with out_ready=1 -> 34 consecutive transfers:
  - (0,80), then (1,20) x16, then (0,C0), then (1,20) x16.
  - dirty=0 from frame start; frame_busy low one cycle after the last transfer.
- Write 8'h48 to addr 0, 8'h69 to addr 1, 8'h32 to addr 17, then idle -> one frame with:
  - byte 1 = 48, byte 2 = 69, byte 19 = 32; all other data bytes 20.
- Hold out_ready=0 for 5 cycles while byte 3 is offered:
  - out_valid, out_rs and out_byte stay constant.
  - The frame resumes with no skipped or duplicated byte; total remains 34.
- During a frame, after position 2 has transferred, write 8'h41 to addr 2:
  - current frame carries the old value; dirty=1.
  - The second frame starts immediately after and carries 41 at position 2.
- Assert clr and wr_en (addr 5, 8'h4B) in the same cycle -> next frame is all 20 except position 5 = 4B.
- Assert rst_n=0 at transfer 10:
  - out_valid=0 and frame_busy=0 after that edge.
  - After release, a full blank frame follows.
  - With LCD_CHAR_BUFFER_INIT_EN, the frame is preceded by 28, 06, 0C, 01.

Source files
------------

// File: rtl/lcd_char_buffer.sv
// 2x16 ASCII screen buffer that streams a full refresh frame (command/data bytes) to the LCD writer.
// Optional macro LCD_CHAR_BUFFER_INIT_EN prepends a four-byte LCD init sequence to the first frame after reset.
module lcd_char_buffer #(
    parameter logic [7:0] BLANK     = 8'h20,
    parameter logic [7:0] LINE1_CMD = 8'h80,
    parameter logic [7:0] LINE2_CMD = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_byte,
    output logic       frame_busy,
    output logic       dirty
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_LINE1,
        S_CMD2,
        S_LINE2
`ifdef LCD_CHAR_BUFFER_INIT_EN
        , S_INIT
`endif
    } state_t;

    state_t     r_state;
    logic [7:0] r_mem [32];
    logic [3:0] r_col;
    logic       r_out_valid;
    logic       r_out_rs;
    logic [7:0] r_out_byte;
    logic       r_frame_busy;
    logic       r_dirty;

    logic       w_xfer;
    logic       w_touch;
    logic [3:0] w_col_nxt;

    assign w_xfer     = r_out_valid & out_ready;
    assign w_touch    = wr_en | clr;
    assign w_col_nxt  = r_col + 4'd1;

    assign out_valid  = r_out_valid;
    assign out_rs     = r_out_rs;
    assign out_byte   = r_out_byte;
    assign frame_busy = r_frame_busy;
    assign dirty      = r_dirty;

`ifdef LCD_CHAR_BUFFER_INIT_EN
    logic       r_init_done;
    logic [1:0] r_init_idx;

    function automatic logic [7:0] f_init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction
`endif

    // A later NBA to the written address overrides the clear loop, so clr+wr_en keeps wr_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) r_mem[i] <= BLANK;
        end else begin
            if (clr) begin
                for (int unsigned i = 0; i < 32; i++) r_mem[i] <= BLANK;
            end
            if (wr_en) r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_out_rs     <= 1'b0;
            r_out_byte   <= '0;
            r_frame_busy <= 1'b0;
            r_dirty      <= 1'b1;
`ifdef LCD_CHAR_BUFFER_INIT_EN
            r_init_done  <= 1'b0;
            r_init_idx   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_dirty) begin
                        r_dirty      <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_frame_busy <= 1'b1;
                        r_out_rs     <= 1'b0;
`ifdef LCD_CHAR_BUFFER_INIT_EN
                        if (!r_init_done) begin
                            r_state    <= S_INIT;
                            r_init_idx <= '0;
                            r_out_byte <= f_init_byte(2'd0);
                        end else begin
                            r_state    <= S_CMD1;
                            r_out_byte <= LINE1_CMD;
                        end
`else
                        r_state    <= S_CMD1;
                        r_out_byte <= LINE1_CMD;
`endif
                    end
                end
`ifdef LCD_CHAR_BUFFER_INIT_EN
                S_INIT: begin
                    if (w_xfer) begin
                        if (r_init_idx == 2'd3) begin
                            r_state     <= S_CMD1;
                            r_init_done <= 1'b1;
                            r_out_byte  <= LINE1_CMD;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_out_byte <= f_init_byte(r_init_idx + 2'd1);
                        end
                    end
                end
`endif
                S_CMD1: begin
                    if (w_xfer) begin
                        r_state    <= S_LINE1;
                        r_col      <= '0;
                        r_out_rs   <= 1'b1;
                        r_out_byte <= r_mem[5'd0];
                    end
                end
                S_LINE1: begin
                    if (w_xfer) begin
                        if (r_col == 4'd15) begin
                            r_state    <= S_CMD2;
                            r_col      <= '0;
                            r_out_rs   <= 1'b0;
                            r_out_byte <= LINE2_CMD;
                        end else begin
                            r_col      <= w_col_nxt;
                            r_out_byte <= r_mem[{1'b0, w_col_nxt}];
                        end
                    end
                end
                S_CMD2: begin
                    if (w_xfer) begin
                        r_state    <= S_LINE2;
                        r_col      <= '0;
                        r_out_rs   <= 1'b1;
                        r_out_byte <= r_mem[5'd16];
                    end
                end
                S_LINE2: begin
                    if (w_xfer) begin
                        if (r_col == 4'd15) begin
                            r_state      <= S_IDLE;
                            r_col        <= '0;
                            r_out_valid  <= 1'b0;
                            r_frame_busy <= 1'b0;
                        end else begin
                            r_col      <= w_col_nxt;
                            r_out_byte <= r_mem[{1'b1, w_col_nxt}];
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_out_valid  <= 1'b0;
                    r_frame_busy <= 1'b0;
                end
            endcase
            // A write or clear in the frame-start cycle keeps dirty set.
            if (w_touch) r_dirty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Scoreboard bench for lcd_char_buffer: stimulus pushes expected {rs,byte} frames, a monitor pops on each transfer.
module tb_lcd_char_buffer;

`ifdef LCD_CHAR_BUFFER_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic       out_rs;
    logic [7:0] out_byte;
    logic       frame_busy;
    logic       dirty;

    int         checks = 0;
    int         errors = 0;
    int         xfer_cnt = 0;
    logic [8:0] q[$];
    logic [7:0] tb_mem [32];

    always #5 clk = ~clk;

    lcd_char_buffer #(
        .BLANK(8'h20),
        .LINE1_CMD(8'h80),
        .LINE2_CMD(8'hC0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .clr(clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rs(out_rs),
        .out_byte(out_byte),
        .frame_busy(frame_busy),
        .dirty(dirty)
    );

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            logic [8:0] exp_v;
            xfer_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected #%0d: got rs=%0b byte=%02h, required none", xfer_cnt, out_rs, out_byte);
            end else begin
                exp_v = q.pop_front();
                if ({out_rs, out_byte} !== exp_v) begin
                    errors++;
                    $display("FAIL xfer #%0d: got rs=%0b byte=%02h, required rs=%0b byte=%02h",
                             xfer_cnt, out_rs, out_byte, exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blank_model();
        for (int i = 0; i < 32; i++) tb_mem[i] = 8'h20;
    endtask

    task automatic push_frame(input bit with_init);
        if (with_init && INIT_EN) begin
            q.push_back({1'b0, 8'h28});
            q.push_back({1'b0, 8'h06});
            q.push_back({1'b0, 8'h0C});
            q.push_back({1'b0, 8'h01});
        end
        q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) q.push_back({1'b1, tb_mem[i]});
        q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) q.push_back({1'b1, tb_mem[i]});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes pending, required 0", name, q.size());
        end
        check({name, "_busy_end"}, {31'd0, frame_busy}, 32'd0);
        check({name, "_valid_end"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic write1(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tb_mem[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0; out_ready = 1'b1;
        blank_model();
        repeat (3) step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_rs", {31'd0, out_rs}, 32'd0);
        check("rst_byte", {24'd0, out_byte}, 32'd0);
        check("rst_dirty", {31'd0, dirty}, 32'd1);

        // Blank frame right after reset
        push_frame(1'b1);
        rst_n = 1'b1;
        step();
        check("start_dirty", {31'd0, dirty}, 32'd0);
        check("start_busy", {31'd0, frame_busy}, 32'd1);
        check("start_valid", {31'd0, out_valid}, 32'd1);
        drain("blank");

        // Writes while stalled: frame starts mid-write, dirty stays set, two frames follow
        out_ready = 1'b0;
        write1(5'd0, 8'h48);
        write1(5'd1, 8'h69);
        write1(5'd17, 8'h32);
        check("wr_dirty_held", {31'd0, dirty}, 32'd1);
        push_frame(1'b0);
        push_frame(1'b0);
        out_ready = 1'b1;
        drain("hi");

        // Stall on byte 3, then write a position already sent
        out_ready = 1'b0;
        write1(5'd3, 8'h33);
        push_frame(1'b0);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_rs", {31'd0, out_rs}, 32'd1);
            check("stall_byte", {24'd0, out_byte}, {24'd0, tb_mem[2]});
            step();
        end
        check("stall_dirty", {31'd0, dirty}, 32'd0);
        out_ready = 1'b1;
        step();
        write1(5'd2, 8'h41);
        check("late_wr_dirty", {31'd0, dirty}, 32'd1);
        push_frame(1'b0);
        drain("late");

        // clr and wr_en together
        clr = 1'b1;
        blank_model();
        write1(5'd5, 8'h4B);
        clr = 1'b0;
        push_frame(1'b0);
        drain("clrwr");

        // Reset in the middle of a frame
        base = xfer_cnt;
        write1(5'd31, 8'h5A);
        push_frame(1'b0);
        for (int i = 0; i < 100 && xfer_cnt < base + 10; i++) step();
        check("mid_xfer_cnt", xfer_cnt - base, 32'd10);
        rst_n = 1'b0;
        step();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, frame_busy}, 32'd0);
        check("midrst_dirty", {31'd0, dirty}, 32'd1);
        q.delete();
        blank_model();
        push_frame(1'b1);
        rst_n = 1'b1;
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
